// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 constants, FSM state type and byte-level helper functions.
// Used by the iterative encryption controller, its key step and MixColumns.
// Byte packing everywhere: FIPS-197 byte n sits at bits [8n+7:8n],
// column c = bytes 4c..4c+3.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_W  = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // S-box computed as multiplicative inverse (b^254, 0 maps to 0)
    // followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = b;
        for (int i = 0; i < 8; i++) begin
            // 254 = 8'b1111_1110: every exponent bit except bit 0
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [AES_W-1:0] sub_bytes128(input logic [AES_W-1:0] s);
        logic [AES_W-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Output byte (r + 4c) = input byte (r + 4((c + r) mod 4)).
    function automatic logic [AES_W-1:0] shift_rows128(input logic [AES_W-1:0] s);
        logic [AES_W-1:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// ---------------------------------------------------------------------------
// aes_key_step
// One AES-128 key-schedule step: derives the next round key from the
// current one. Combinational; also intended for the decryption key
// precompute.
// Ports:
//   key      in  [127:0]  current round key, w0 = bits [31:0]
//   rcon     in  [7:0]    round constant for this step
//   next_key out [127:0]  following round key
// ---------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  logic [AES_W-1:0] key,
    input  logic [7:0]       rcon,
    output logic [AES_W-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = key[31:0];
    assign w1 = key[63:32];
    assign w2 = key[95:64];
    assign w3 = key[127:96];

    // RotWord moves byte 0 of w3 to the top byte.
    assign rot = {w3[7:0], w3[31:8]};
    assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {24'h0, rcon};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n3, n2, n1, n0};

endmodule

// File: rtl/mix_columns.sv
// ---------------------------------------------------------------------------
// mix_columns
// Combinational AES MixColumns over all four columns.
// Ports:
//   data   in  [127:0]  state after ShiftRows
//   result out [127:0]  mixed state
// ---------------------------------------------------------------------------
module mix_columns
    import aes_pkg::*;
(
    input  logic [AES_W-1:0] data,
    output logic [AES_W-1:0] result
);

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        // 3*a = xtime(a) ^ a
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

    always_comb begin
        result = '0;
        for (int c = 0; c < 4; c++) begin
            result[32*c +: 32] = mix_col(data[32*c +: 32]);
        end
    end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_iter_ctrl
// Iterative AES-128 encryption controller: one round per clock, key
// schedule computed on the fly, valid/ready on both sides.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready plaintext+key handshake (in_ready high only in IDLE)
//   in_data, in_key   plaintext and cipher key, sampled on accept edge
//   out_valid/out_ready ciphertext handshake
//   out_data          ciphertext (state register)
//   busy              high in RUN or DONE
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | one AES round per cycle, rounds 1..10
// DONE  | ciphertext presented until out_ready
// ---------------------------------------------------------------------------
module aes128_iter_ctrl
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AES_W-1:0] in_data,
    input  logic [AES_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AES_W-1:0] out_data,
    output logic             busy
);

    localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

    aes_state_e       fsm;
    logic [AES_W-1:0] state_reg;
    logic [AES_W-1:0] key_reg;
    logic [7:0]       rcon_reg;
    logic [3:0]       round;

    logic [AES_W-1:0] sr_out;
    logic [AES_W-1:0] mc_out;
    logic [AES_W-1:0] rk_next;
    logic [AES_W-1:0] round_out;

    assign sr_out = shift_rows128(sub_bytes128(state_reg));

    mix_columns u_mix_columns (
        .data   (sr_out),
        .result (mc_out)
    );

    aes_key_step u_key_step (
        .key      (key_reg),
        .rcon     (rcon_reg),
        .next_key (rk_next)
    );

    // Final round skips MixColumns.
    assign round_out = ((round == LAST_ROUND) ? sr_out : mc_out) ^ rk_next;

    assign out_data = state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= ST_IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rcon_reg  <= 8'h00;
            round     <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data ^ in_key;
                        key_reg   <= in_key;
                        rcon_reg  <= 8'h01;
                        round     <= 4'd1;
                        fsm       <= ST_RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (round == 4'd0 || round > LAST_ROUND) begin
                        // corrupted counter: drop the block
                        fsm       <= ST_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        state_reg <= round_out;
                        key_reg   <= rk_next;
                        rcon_reg  <= xtime(rcon_reg);
                        if (round == LAST_ROUND) begin
                            fsm       <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm       <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes128_iter_ctrl
// Self-checking bench for aes128_iter_ctrl: FIPS-197 vectors, backpressure,
// busy-time input noise, mid-run reset, back-to-back blocks and random
// blocks compared against a byte-array AES reference model.
// ---------------------------------------------------------------------------
module tb_aes128_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_t [256];

    aes128_iter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // in_ready and out_valid must never be high together
    always @(negedge clk) begin
        if (rst === 1'b0) chk("excl", {127'd0, in_ready & out_valid}, 128'd0);
    end

    // FIPS hex string order (byte 0 first) to bus packing (byte 0 at LSB)
    function automatic logic [127:0] fips(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[8*n +: 8] = s[127-8*n -: 8];
        return o;
    endfunction

    function automatic logic [7:0] m2(input logic [7:0] a);
        return (a << 1) ^ ((a & 8'h80) != 0 ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 0) begin
            if (y[0]) r ^= x;
            x = m2(x);
            y = y >> 1;
        end
        return r;
    endfunction

    // S-box by brute-force inverse search plus bitwise affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c = 8'h63;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [44][4];
        logic [7:0] tmp [4];
        logic [7:0] a [4];
        logic [7:0] rc;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8];
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp[0] = sbox_t[w[i-1][1]] ^ rc;
                tmp[1] = sbox_t[w[i-1][2]];
                tmp[2] = sbox_t[w[i-1][3]];
                tmp[3] = sbox_t[w[i-1][0]];
                rc = m2(rc);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] ^= w[i/4][i%4];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
                    t[4*c+0] = m2(a[0]) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                    t[4*c+1] = a[0] ^ m2(a[1]) ^ gmul(a[2], 8'h03) ^ a[3];
                    t[4*c+2] = a[0] ^ a[1] ^ m2(a[2]) ^ gmul(a[3], 8'h03);
                    t[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ m2(a[3]);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*c] ^ w[4*rnd+c][r];
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
        return o;
    endfunction

    task automatic accept_block(input logic [127:0] pt, input logic [127:0] key);
        int wcyc = 0;
        while (!in_ready && wcyc < 40) begin
            @(posedge clk); #1;
            wcyc++;
        end
        chk("accept_wait", {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("acc_busy", {127'd0, busy}, 128'd1);
        chk("acc_rdy", {127'd0, in_ready}, 128'd0);
    endtask

    task automatic finish_block(input int start_cyc, input int stall, input bit noise,
                                input logic [127:0] exp);
        int cyc = start_cyc;
        logic [127:0] held;
        out_ready = (stall == 0);
        while (!out_valid && cyc < 40) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("latency", 128'(cyc), 128'd10);
        chk("ct", out_data, exp);
        chk("done_busy", {127'd0, busy}, 128'd1);
        chk("done_rdy", {127'd0, in_ready}, 128'd0);
        held = out_data;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk("bp_data", out_data, held);
            chk("bp_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_rdy", {127'd0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid", {127'd0, out_valid}, 128'd0);
        chk("hs_rdy", {127'd0, in_ready}, 128'd1);
        chk("hs_busy", {127'd0, busy}, 128'd0);
        out_ready = 1'b0;
    endtask

    logic [127:0] pt_c1, key_c1, ct_c1, pt_b, key_b, ct_b, rk1_b;
    logic [127:0] rpt, rkey;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
        build_sbox();
        pt_c1  = fips(128'h00112233445566778899aabbccddeeff);
        key_c1 = fips(128'h000102030405060708090a0b0c0d0e0f);
        ct_c1  = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        pt_b   = fips(128'h3243f6a8885a308d313198a2e0370734);
        key_b  = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        ct_b   = fips(128'h3925841d02dc09fbdc118597196a0b32);
        rk1_b  = fips(128'ha0fafe1788542cb123a339392a6c7605);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);

        // C.1 with out_ready held high
        accept_block(pt_c1, key_c1);
        finish_block(0, 0, 1'b0, ct_c1);
        chk("model_c1", ref_encrypt(pt_c1, key_c1), ct_c1);

        // Appendix B with round-1 key check and 5-cycle backpressure
        accept_block(pt_b, key_b);
        @(posedge clk); #1;
        chk("rk1", dut.key_reg, rk1_b);
        finish_block(1, 5, 1'b0, ct_b);

        // busy-time input noise
        accept_block(pt_c1, key_c1);
        finish_block(0, 2, 1'b1, ct_c1);

        // reset at round 5
        accept_block(pt_b, key_b);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_rdy", {127'd0, in_ready}, 128'd1);
        chk("mrst_valid", {127'd0, out_valid}, 128'd0);
        chk("mrst_data", out_data, 128'd0);
        chk("mrst_busy", {127'd0, busy}, 128'd0);
        accept_block(pt_c1, key_c1);
        finish_block(0, 0, 1'b0, ct_c1);

        // back-to-back: in_valid held high, B then C.1
        begin
            int cyc = 0;
            out_ready = 1'b1;
            in_valid = 1'b1; in_data = pt_b; in_key = key_b;
            @(posedge clk); #1;
            chk("b2b_acc1", {127'd0, busy}, 128'd1);
            in_data = pt_c1; in_key = key_c1;
            while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
            chk("b2b_lat1", 128'(cyc), 128'd10);
            chk("b2b_ct1", out_data, ct_b);
            @(posedge clk); #1;
            chk("b2b_hs_rdy", {127'd0, in_ready}, 128'd1);
            chk("b2b_hs_busy", {127'd0, busy}, 128'd0);
            @(posedge clk); #1;
            chk("b2b_acc2", {127'd0, busy}, 128'd1);
            in_valid = 1'b0;
            cyc = 0;
            while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
            chk("b2b_lat2", 128'(cyc), 128'd10);
            chk("b2b_ct2", out_data, ct_c1);
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("b2b_end_rdy", {127'd0, in_ready}, 128'd1);
        end

        // random blocks against the reference model
        for (int n = 0; n < 6; n++) begin
            rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            accept_block(rpt, rkey);
            finish_block(0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         ref_encrypt(rpt, rkey));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
